color_event_tracker: RTL

Consumes the 2-bit color code from the color detector (1=red, 2=green, 3=blue, 0=none) and turns it into discrete node events for the line-follower controller. It synchronizes the code into the system clock domain, rejects glitches, numbers each new color marker, drives the RGB indicator LED for a fixed hold time, and queues events in a small FIFO with a valid/ready output toward the path-planning / messaging stage.

---
 rtl/color_event_tracker.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/color_event_tracker.sv
// color_event_tracker: synchronizes and debounces the detector color code, numbers node events,
// queues them in a FWFT FIFO and, when COLOR_EVT_LED_EN is defined, drives a timed RGB indicator.
module color_event_tracker #(
    parameter int STABLE_CYCLES   = 4000,
    parameter int LED_HOLD_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4,
    parameter int NODE_W          = 5
) (
    input  logic              clk_1MHz,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        color,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [1:0]        evt_color,
    output logic [NODE_W-1:0] evt_node,
    output logic [2:0]        led_rgb,
    output logic              led_busy,
    output logic              overflow
);

    localparam int CNT_W   = $clog2(STABLE_CYCLES);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FILL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = 2 + NODE_W;

    generate
        if (STABLE_CYCLES < 2 || LED_HOLD_CYCLES < 1 || FIFO_DEPTH < 1 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || NODE_W < 1) begin : gBadParams
            $error("color_event_tracker: illegal parameter set");
        end
    endgenerate

    logic [1:0] colorMeta_q, colorSync_q;
    logic       enMeta_q, enSync_q;

    always_ff @(posedge clk_1MHz or posedge reset) begin
        if (reset) begin
            colorMeta_q <= 2'd0;
            colorSync_q <= 2'd0;
            enMeta_q    <= 1'b0;
            enSync_q    <= 1'b0;
        end else begin
            colorMeta_q <= color;
            colorSync_q <= colorMeta_q;
            enMeta_q    <= en;
            enSync_q    <= enMeta_q;
        end
    end

    logic [1:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        stable_q, stable_d;
    logic [1:0]        last_q, last_d;
    logic [NODE_W-1:0] node_q, node_d;
    logic              evtFire;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (colorSync_q != cand_q) begin
            cand_d = colorSync_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_W'(STABLE_CYCLES - 1)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            stable_d = cand_q;
        end
    end

    // The event looks at the filter's next value so it fires on the same edge stable updates;
    // a return to "none" leaves last alone, so red->none->red reports red only once.
    always_comb begin
        evtFire = enSync_q && (stable_d != 2'd0) && (stable_d != last_q);
        last_d  = last_q;
        if (!enSync_q) begin
            last_d = 2'd0;
        end else if (evtFire) begin
            last_d = stable_d;
        end
        node_d = evtFire ? node_q + 1'b1 : node_q;
    end

    always_ff @(posedge clk_1MHz or posedge reset) begin
        if (reset) begin
            cand_q   <= 2'd0;
            cnt_q    <= '0;
            stable_q <= 2'd0;
            last_q   <= 2'd0;
            node_q   <= '0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            last_q   <= last_d;
            node_q   <= node_d;
        end
    end

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               overflow_q, overflow_d;
    logic               fifoFull, doPop, doPush;
    logic [ENTRY_W-1:0] headEntry;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifoFull  = (fill_q == FILL_W'(FIFO_DEPTH));
    assign evt_valid = (fill_q != '0);
    assign doPop     = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
    assign doPush    = evtFire && (!fifoFull || doPop);

    always_comb begin
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q || (evtFire && fifoFull && !doPop);
        if (doPush) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end
        if (doPop) begin
            rdPtr_d = nextPtr(rdPtr_q);
        end
        unique case ({doPush, doPop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk_1MHz or posedge reset) begin
        if (reset) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_1MHz) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= {stable_d, node_q};
        end
    end

    assign headEntry = mem_q[rdPtr_q];
    assign evt_color = evt_valid ? headEntry[ENTRY_W-1 -: 2] : 2'd0;
    assign evt_node  = evt_valid ? headEntry[NODE_W-1:0] : '0;
    assign overflow  = overflow_q;

`ifdef COLOR_EVT_LED_EN
    localparam int TMR_W = (LED_HOLD_CYCLES > 1) ? $clog2(LED_HOLD_CYCLES) : 1;

    typedef enum logic {
        LED_IDLE,
        LED_HOLD
    } ledState_e;

    ledState_e        ledState_q, ledState_d;
    logic [TMR_W-1:0] ledTimer_q, ledTimer_d;
    logic [1:0]       ledColor_q, ledColor_d;

    always_ff @(posedge clk_1MHz or posedge reset) begin
        if (reset) begin
            ledState_q <= LED_IDLE;
            ledTimer_q <= '0;
            ledColor_q <= 2'd0;
        end else begin
            ledState_q <= ledState_d;
            ledTimer_q <= ledTimer_d;
            ledColor_q <= ledColor_d;
        end
    end

    // A new event always wins, restarting the hold with its own color.
    always_comb begin
        ledState_d = ledState_q;
        ledTimer_d = ledTimer_q;
        ledColor_d = ledColor_q;
        if (evtFire) begin
            ledState_d = LED_HOLD;
            ledTimer_d = TMR_W'(LED_HOLD_CYCLES - 1);
            ledColor_d = stable_d;
        end else if (ledState_q == LED_HOLD) begin
            if (ledTimer_q == '0) begin
                ledState_d = LED_IDLE;
            end else begin
                ledTimer_d = ledTimer_q - 1'b1;
            end
        end
    end

    always_comb begin
        led_rgb  = 3'b000;
        led_busy = 1'b0;
        if (ledState_q == LED_HOLD) begin
            led_busy = 1'b1;
            case (ledColor_q)
                2'd1:    led_rgb = 3'b100;
                2'd2:    led_rgb = 3'b010;
                2'd3:    led_rgb = 3'b001;
                default: led_rgb = 3'b000;
            endcase
        end
    end
`else
    assign led_rgb  = 3'b000;
    assign led_busy = 1'b0;
`endif

endmodule
